// File: rtl/k051316_roz_if.sv
// ----------------------------------------------------------------------------
// k051316_roz_if -- CPU-side select/address bus for the K051316 ROZ block.
//
// Signals:
//   IOCS  register-file select, active low
//   VRCS  VRAM select, active low
//   RW    1 = read, 0 = write
//   A     11-bit CPU address
// The 8-bit data bus is bidirectional and is carried as a separate inout port
// on the block so the tristate resolves at a single net.
//
// Modports: master (CPU / bench drives), slave (ROZ block samples).
// ----------------------------------------------------------------------------
interface k051316_roz_if;
    logic        IOCS;
    logic        VRCS;
    logic        RW;
    logic [10:0] A;

    modport master (output IOCS, VRCS, RW, A);
    modport slave  (input  IOCS, VRCS, RW, A);
endinterface

// File: rtl/k051316_roz.sv
// ----------------------------------------------------------------------------
// k051316_roz -- rotate/zoom tilemap address generator (K051316 style).
//
// Two 24-bit accumulator pairs (line / pixel) walk an affine path through a
// 32x32 tilemap held in a 2048x8 VRAM (codes at 0-1023, attributes at
// 1024-2047) and produce a ROM address CA = {attr, code, fy, fx} per pixel.
//
// Ports:
//   M12        master clock, all logic on its rising edge
//   RST        synchronous active-high reset
//   M6         pixel phase; its rising edge (seen in M12) is the pixel tick
//   bus        CPU select/address bus (k051316_roz_if.slave)
//   D          8-bit CPU data, inout; driven only for VRAM reads
//   VSCN/HSCN  vertical / horizontal active display
//   VRC        vertical reset (qualifies HRC to reload start values)
//   HRC        line start pulse (rising edge)
//   CA         24-bit ROM address
//   OBLK       out-of-bounds blank
//
// Build option: K051316_ROMREAD_EN -- when defined and reg14 bit0 = 0, CA
// becomes the CPU ROM readback address {5'b0, reg12, A} and OBLK = 0.
// ----------------------------------------------------------------------------
module k051316_roz (
    input  logic         M12,
    input  logic         RST,
    input  logic         M6,
    k051316_roz_if.slave bus,
    inout  wire  [7:0]   D,
    input  logic         VSCN,
    input  logic         HSCN,
    input  logic         VRC,
    input  logic         HRC,
    output logic [23:0]  CA,
    output logic         OBLK
);

    logic [7:0]  regs [16];
    logic [7:0]  vram [2048];

    logic        reg_we, vram_we, vram_rd;
    assign reg_we  = !bus.IOCS && !bus.RW;
    assign vram_we = !bus.VRCS && !bus.RW;
    assign vram_rd = !bus.VRCS &&  bus.RW;

    // Big-endian register pairs.
    logic [15:0] x_start, x_pix_inc, x_line_inc, y_start, y_pix_inc, y_line_inc;
    assign x_start    = {regs[0],  regs[1]};
    assign x_pix_inc  = {regs[2],  regs[3]};
    assign x_line_inc = {regs[4],  regs[5]};
    assign y_start    = {regs[6],  regs[7]};
    assign y_pix_inc  = {regs[8],  regs[9]};
    assign y_line_inc = {regs[10], regs[11]};

    function automatic logic [23:0] sext(input logic [15:0] v);
        return {{8{v[15]}}, v};
    endfunction

    // ---------------- CPU register file ----------------
    always_ff @(posedge M12) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[bus.A[3:0]] <= D;
        end
    end

    // ---------------- VRAM (contents survive reset) ----------------
    always_ff @(posedge M12) begin
        if (vram_we) vram[bus.A] <= D;
    end

    // CPU read has its own port, so video fetches never stall it.
    logic [7:0] d_q;
    always_ff @(posedge M12) begin
        if (RST)          d_q <= '0;
        else if (vram_rd) d_q <= vram[bus.A];
    end
    assign D = (vram_rd && !RST) ? d_q : 8'hzz;

    // ---------------- edge detection ----------------
    logic m6_q, hrc_q, pix_tick, hrc_rise;
    always_ff @(posedge M12) begin
        if (RST) begin
            m6_q  <= 1'b0;
            hrc_q <= 1'b0;
        end else begin
            m6_q  <= M6;
            hrc_q <= HRC;
        end
    end
    assign pix_tick = M6  && !m6_q;
    assign hrc_rise = HRC && !hrc_q;

    // ---------------- accumulators ----------------
    logic [23:0] line_x, line_y, pix_x, pix_y, next_lx, next_ly;
    logic        line_act;   // cleared by reset so a cut-off line stays dead until HRC
    logic        act_tick;

    assign next_lx  = VRC ? {x_start, 8'h00} : line_x + sext(x_line_inc);
    assign next_ly  = VRC ? {y_start, 8'h00} : line_y + sext(y_line_inc);
    assign act_tick = pix_tick && HSCN && VSCN && line_act;

    always_ff @(posedge M12) begin
        if (RST) begin
            line_x <= '0; line_y <= '0;
            pix_x  <= '0; pix_y  <= '0;
            line_act <= 1'b0;
        end else if (hrc_rise) begin
            line_x <= next_lx; line_y <= next_ly;
            pix_x  <= next_lx; pix_y  <= next_ly;
            line_act <= 1'b1;
        end else if (act_tick) begin
            pix_x <= pix_x + sext(x_pix_inc);
            pix_y <= pix_y + sext(y_pix_inc);
        end
    end

    // ---------------- two-stage output pipeline ----------------
    // Stage 1 samples the accumulators and fetches code/attr; stage 2 applies
    // flips and forms CA. Both advance only on active ticks, so CA/OBLK hold
    // through blanking. A new line flushes stage 1 so no pixel leaks across.
    logic [9:0]  tile_idx;
    logic [7:0]  code_q, attr_q;
    logic [3:0]  fx_q, fy_q, fx_o, fy_o;
    logic        oob_q, s1_vld;
    logic [23:0] ca_q;
    logic        oblk_q;

    assign tile_idx = {pix_y[19:15], pix_x[19:15]};
    assign fx_o = fx_q ^ {4{regs[14][1] & attr_q[6]}};
    assign fy_o = fy_q ^ {4{regs[14][2] & attr_q[7]}};

    always_ff @(posedge M12) begin
        if (RST) begin
            code_q <= '0; attr_q <= '0; fx_q <= '0; fy_q <= '0;
            oob_q  <= 1'b0; s1_vld <= 1'b0;
            ca_q   <= '0;   oblk_q <= 1'b1;
        end else if (hrc_rise) begin
            s1_vld <= 1'b0;
        end else if (act_tick) begin
            code_q <= vram[{1'b0, tile_idx}];
            attr_q <= vram[{1'b1, tile_idx}];
            fx_q   <= pix_x[14:11];
            fy_q   <= pix_y[14:11];
            oob_q  <= (|pix_x[23:20]) || (|pix_y[23:20]);
            s1_vld <= 1'b1;
            if (s1_vld) begin
                ca_q   <= {attr_q, code_q, fy_o, fx_o};
                oblk_q <= oob_q && !regs[13][0];
            end
        end
    end

`ifdef K051316_ROMREAD_EN
    always_comb begin
        CA   = ca_q;
        OBLK = oblk_q;
        if (!regs[14][0]) begin
            CA   = {5'b0, regs[12], bus.A};
            OBLK = 1'b0;
        end
    end
`else
    assign CA   = ca_q;
    assign OBLK = oblk_q;
`endif

    // Fraction bits and spare register bits are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{regs[12], regs[13][7:1], regs[14][7:3], regs[14][0],
                           regs[15], pix_x[10:0], pix_y[10:0]};

endmodule

// File: tb/tb_k051316_roz.sv
// Directed bench for k051316_roz: tilemap walk, line stepping with Y flip,
// out-of-range blanking vs wrap, reset behaviour and CPU VRAM readback.
module tb_k051316_roz;
    logic        M12 = 1'b0;
    logic        RST, M6, VSCN, HSCN, VRC, HRC;
    logic [23:0] CA;
    logic        OBLK;
    logic [7:0]  d_drv;
    logic        d_en;
    wire  [7:0]  d_bus;

    int errors = 0;
    int checks = 0;

`ifdef K051316_ROMREAD_EN
    localparam bit ROMRD = 1'b1;
`else
    localparam bit ROMRD = 1'b0;
`endif

    assign d_bus = d_en ? d_drv : 8'hzz;

    k051316_roz_if bus ();

    k051316_roz dut (
        .M12(M12), .RST(RST), .M6(M6), .bus(bus), .D(d_bus),
        .VSCN(VSCN), .HSCN(HSCN), .VRC(VRC), .HRC(HRC),
        .CA(CA), .OBLK(OBLK)
    );

    always #5 M12 = ~M12;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        bus.IOCS = 1'b0; bus.RW = 1'b0; bus.A = {7'd0, a}; d_drv = d; d_en = 1'b1;
        @(negedge M12);
        bus.IOCS = 1'b1; bus.RW = 1'b1; bus.A = '0; d_en = 1'b0;
    endtask

    task automatic wr_vram(input logic [10:0] a, input logic [7:0] d);
        bus.VRCS = 1'b0; bus.RW = 1'b0; bus.A = a; d_drv = d; d_en = 1'b1;
        @(negedge M12);
        bus.VRCS = 1'b1; bus.RW = 1'b1; bus.A = '0; d_en = 1'b0;
    endtask

    task automatic rd_vram(input logic [10:0] a, output logic [7:0] d);
        bus.VRCS = 1'b0; bus.RW = 1'b1; bus.A = a;
        @(negedge M12);
        d = d_bus;
        bus.VRCS = 1'b1; bus.A = '0;
        @(negedge M12);
    endtask

    task automatic pix();
        M6 = 1'b1; @(negedge M12);
        M6 = 1'b0; @(negedge M12);
    endtask

    task automatic line(input logic vrc);
        VRC = vrc; HRC = 1'b1; @(negedge M12);
        HRC = 1'b0; @(negedge M12);
        VRC = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1; @(negedge M12); @(negedge M12);
        RST = 1'b0; @(negedge M12);
    endtask

    logic [23:0] exp_ca, last_ca;
    logic [9:0]  idx;
    logic [7:0]  rd;
    logic [3:0]  fy;

    initial begin
        RST = 1'b1; M6 = 1'b0; VSCN = 1'b0; HSCN = 1'b0; VRC = 1'b0; HRC = 1'b0;
        bus.IOCS = 1'b1; bus.VRCS = 1'b1; bus.RW = 1'b1; bus.A = '0;
        d_drv = '0; d_en = 1'b0;
        @(negedge M12);
        do_reset();
        check("reset_ca",   CA, 24'h0);
        check("reset_oblk", {23'd0, OBLK}, {23'd0, !ROMRD});

        // VRAM: code = i[7:0], attr = 0x80 | i[15:8]
        for (int i = 0; i < 1024; i++) begin
            wr_vram(i[10:0], i[7:0]);
            wr_vram(11'h400 + i[10:0], 8'h80 | i[15:8]);
        end

        // ---- X walk, one pixel per tick, Y flipped ----
        wr_reg(4'd2, 8'h08); wr_reg(4'd3, 8'h00); wr_reg(4'd14, 8'h05);
        line(1'b1);
        VSCN = 1'b1; HSCN = 1'b1;
        pix();
        check("walk_first_tick_hold", CA, 24'h0);
        for (int t = 2; t < 36; t++) begin
            int p;
            pix();
            p = t - 2;
            exp_ca = {8'h80, 8'(p >> 4), 4'hF, 4'(p)};
            check($sformatf("walk_p%0d", p), CA, exp_ca);
            check($sformatf("walk_oblk_p%0d", p), {23'd0, OBLK}, 24'd0);
        end
        last_ca = {8'h80, 8'd2, 4'hF, 4'd1};
        HSCN = 1'b0;
        for (int t = 0; t < 3; t++) begin
            pix();
            check($sformatf("hblank_hold_%0d", t), CA, last_ca);
        end

        // ---- line stepping: Y +1 pixel per line, no pixel motion ----
        do_reset();
        wr_reg(4'd10, 8'h08); wr_reg(4'd11, 8'h00); wr_reg(4'd14, 8'h05);
        HSCN = 1'b1;
        for (int n = 0; n < 18; n++) begin
            line(n == 0);
            pix(); pix();
            idx = 10'((n >> 4) * 32);
            fy  = 4'(n);
            exp_ca = {8'h80 | {6'd0, idx[9:8]}, idx[7:0], ~fy, 4'h0};
            check($sformatf("line_%0d", n), CA, exp_ca);
        end

        // ---- Y underflow, wrap off then on ----
        for (int w = 0; w < 2; w++) begin
            do_reset();
            wr_reg(4'd8, 8'hFF); wr_reg(4'd9, 8'hFE); wr_reg(4'd14, 8'h05);
            wr_reg(4'd13, w[7:0]);
            line(1'b1);
            pix(); pix();
            check($sformatf("uflow_w%0d_first_oblk", w), {23'd0, OBLK}, 24'd0);
            check($sformatf("uflow_w%0d_first_ca", w), CA, 24'h8000F0);
            pix();
            check($sformatf("uflow_w%0d_oblk", w), {23'd0, OBLK}, {23'd0, (w == 0)});
            check($sformatf("uflow_w%0d_ca", w), CA, 24'h83E000);
        end

        // ---- reset in mid-line ----
        do_reset();
        wr_reg(4'd2, 8'h08); wr_reg(4'd3, 8'h00); wr_reg(4'd14, 8'h05);
        line(1'b1);
        for (int t = 0; t < 5; t++) pix();
        check("pre_reset_ca", CA, 24'h8000F3);
        RST = 1'b1; @(negedge M12);
        RST = 1'b0; @(negedge M12);
        check("midreset_ca",   CA, 24'h0);
        check("midreset_oblk", {23'd0, OBLK}, {23'd0, !ROMRD});
        for (int t = 0; t < 3; t++) pix();
        check("aborted_line_ca",   CA, 24'h0);
        check("aborted_line_oblk", {23'd0, OBLK}, {23'd0, !ROMRD});
        // Cleared regs: no flip, zero increments -> pixel (0,0) forever.
        line(1'b1);
        pix(); pix();
        check("regs_cleared_ca", CA, ROMRD ? 24'h0 : 24'h800000);
        pix(); pix(); pix();
        check("regs_cleared_still", CA, ROMRD ? 24'h0 : 24'h800000);
        check("regs_cleared_oblk", {23'd0, OBLK}, 24'd0);

        // ---- CPU VRAM readback ----
        HSCN = 1'b0; VSCN = 1'b0;
        wr_vram(11'h400, 8'h5A);
        rd_vram(11'h400, rd);
        check("vram_rd_400", {16'd0, rd}, 24'h00005A);
        rd_vram(11'h005, rd);
        check("vram_rd_005", {16'd0, rd}, 24'h000005);
        rd_vram(11'h7FF, rd);
        check("vram_rd_7ff", {16'd0, rd}, 24'h000083);

`ifdef K051316_ROMREAD_EN
        do_reset();
        wr_reg(4'd12, 8'h3A);
        bus.A = 11'h123;
        @(negedge M12);
        check("romread_ca",   CA, 24'h01D123);
        check("romread_oblk", {23'd0, OBLK}, 24'd0);
        bus.A = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
